mult_job_sequencer: RTL and testbench

Handshake front/back end for the sequential 8x8 multiplier. It buffers operand pairs from a valid/ready source and launches one multiplication at a time with a single-cycle start pulse. It waits for the multiplier's done flag, captures the 16-bit product into an output register, and presents it to a valid/ready consumer. It sits directly between the operand source and the multiplier datapath, and directly after the multiplier's product register.

---
 rtl/mult_job_sequencer.sv | 95 +++++++++
 tb/tb_mult_job_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: buffers operand pairs, runs one multiply job at a time, and holds each result for a valid/ready consumer
module mult_job_sequencer #(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        out_err,
  output logic [7:0]  mult_dataa,
  output logic [7:0]  mult_datab,
  output logic        mult_start,
  input  logic        mult_done,
  input  logic [15:0] mult_product,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
  state_t state, state_nx;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [7:0] wait_cnt;
  logic [15:0] head, load_val;
  logic push, pop, load, load_err, slot_free, empty, head_zero;
  assign empty = count == '0;
  assign in_ready = count != FULL;
  assign push = in_valid && in_ready;
  assign head = mem[rd_ptr];
  assign head_zero = head[15:8] == 8'd0 || head[7:0] == 8'd0;
  assign slot_free = !out_valid || out_ready;
  assign busy = state != IDLE || !empty;
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    load = 1'b0;
    load_err = 1'b0;
    load_val = 16'd0;
    case (state)
      IDLE: if (!empty && slot_free) begin
        pop = head_zero;
        load = head_zero;
        state_nx = head_zero ? IDLE : LAUNCH;
      end
      LAUNCH: state_nx = WAIT;
      WAIT: if (mult_done || wait_cnt == LAST) begin
        pop = 1'b1;
        load = 1'b1;
        load_err = !mult_done;
        load_val = mult_done ? mult_product : 16'd0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_a)
    if (!reset_a) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_a, in_b};
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      wait_cnt <= 8'd0;
      mult_start <= 1'b0;
      mult_dataa <= 8'd0;
      mult_datab <= 8'd0;
      out_valid <= 1'b0;
      out_product <= 16'd0;
      out_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      wait_cnt <= state == WAIT ? wait_cnt + 8'd1 : 8'd0;
      mult_start <= state_nx == LAUNCH;
      if (state == IDLE && state_nx == LAUNCH) {mult_dataa, mult_datab} <= head;
      if (load) begin
        out_valid <= 1'b1;
        out_product <= load_val;
        out_err <= load_err;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_job_sequencer.sv
// tb_mult_job_sequencer: randomized scoreboard bench with a behavioural multiplier
module tb_mult_job_sequencer;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic reset_a, in_valid, in_ready, out_valid, out_ready, out_err, mult_start, mult_done, busy;
  logic [7:0] in_a, in_b, mult_dataa, mult_datab;
  logic [15:0] out_product, mult_product;
  typedef struct {logic [7:0] a; logic [7:0] b; bit hang;} st_t;
  logic [15:0] in_q[$];
  st_t st_q[$];
  int n_chk = 0, n_fail = 0, n_starts = 0, s0;
  int fixed_d = 0;
  bit hang_mode = 0, rand_hang = 0, rdone = 0;
  logic [7:0] ra, rb;
  mult_job_sequencer #(.FIFO_DEPTH(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_a(reset_a), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_err(out_err), .mult_dataa(mult_dataa),
    .mult_datab(mult_datab), .mult_start(mult_start), .mult_done(mult_done),
    .mult_product(mult_product), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    logic acc;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    chk("accept", {31'd0, acc}, 1);
    in_valid = 1'b0;
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((busy || out_valid) && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", {31'd0, n < 600}, 1);
  endtask
  task automatic wait_ov();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_ov", {31'd0, out_valid}, 1);
  endtask
  initial begin
    bit active = 0, hang = 0, expect_ov = 0, prev_start = 0, prev_hold = 0;
    int w = 0, d = 0, since_start = 1000;
    logic [7:0] cur_a = 0, cur_b = 0, pa, pb;
    logic [16:0] prev_res = 0;
    logic [15:0] p, exp_p;
    logic exp_e;
    st_t s;
    mult_done = 1'b0;
    mult_product = 16'd0;
    forever begin
      @(negedge clk);
      mult_done = 1'b0;
      mult_product = 16'($urandom);
      if (!reset_a) begin
        active = 0; expect_ov = 0; prev_start = 0; prev_hold = 0; since_start = 1000;
        in_q.delete();
        st_q.delete();
        continue;
      end
      since_start++;
      if (in_valid && in_ready) in_q.push_back({in_a, in_b});
      if (expect_ov) begin
        chk("done_latency", {31'd0, out_valid}, 1);
        expect_ov = 0;
      end
      if (mult_start) begin
        chk("start_len", {31'd0, prev_start}, 0);
        chk("start_gap", {31'd0, since_start >= 3}, 1);
        chk("launch_ov", {31'd0, out_valid}, 0);
        cur_a = mult_dataa;
        cur_b = mult_datab;
        hang = hang_mode || (rand_hang && $urandom_range(0, 5) == 0);
        d = fixed_d != 0 ? fixed_d : int'($urandom_range(1, 6));
        w = 0;
        active = 1;
        since_start = 0;
        n_starts++;
        st_q.push_back('{cur_a, cur_b, hang});
        if ($urandom_range(0, 1) == 1) mult_done = 1'b1;
      end else if (active) begin
        w++;
        chk("wait_ov_low", {31'd0, out_valid}, 0);
        chk("hold_ops", {16'd0, mult_dataa, mult_datab}, {16'd0, cur_a, cur_b});
        if (!hang && w == d) begin
          mult_done = 1'b1;
          mult_product = cur_a * cur_b;
          active = 0;
          expect_ov = 1;
        end else if (hang && w == TIMEOUT) begin
          active = 0;
          expect_ov = 1;
        end
      end
      prev_start = mult_start;
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 1);
        chk("hold_result", {15'd0, out_err, out_product}, {15'd0, prev_res});
      end
      prev_hold = out_valid && !out_ready;
      prev_res = {out_err, out_product};
      if (out_valid && out_ready) begin
        chk("sb_nonempty", {31'd0, in_q.size() != 0}, 1);
        if (in_q.size() != 0) begin
          p = in_q.pop_front();
          pa = p[15:8];
          pb = p[7:0];
          exp_p = 16'd0;
          exp_e = 1'b0;
          if (pa != 0 && pb != 0) begin
            chk("start_rec", {31'd0, st_q.size() != 0}, 1);
            if (st_q.size() != 0) begin
              s = st_q.pop_front();
              chk("start_ops", {16'd0, s.a, s.b}, {16'd0, p});
              exp_p = s.hang ? 16'd0 : 16'(int'(pa) * int'(pb));
              exp_e = s.hang;
            end
          end
          chk("product", {16'd0, out_product}, {16'd0, exp_p});
          chk("err", {31'd0, out_err}, {31'd0, exp_e});
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset_a = 1'b0;
    in_valid = 1'b0;
    in_a = 8'd0;
    in_b = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out", {14'd0, out_valid, out_err, out_product}, 0);
    chk("rst_mult", {15'd0, mult_start, mult_dataa, mult_datab}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1 reset_a = 1'b1;
    // single job 13x11 held until consumed
    fixed_d = 5;
    s0 = n_starts;
    send(8'd13, 8'd11);
    wait_ov();
    repeat (4) begin @(posedge clk); #1; end
    chk("single_prod", {16'd0, out_product}, 143);
    out_ready = 1'b1;
    wait_drain();
    chk("single_starts", n_starts - s0, 1);
    fixed_d = 0;
    // back-to-back
    s0 = n_starts;
    send(8'd255, 8'd255);
    send(8'd16, 8'd16);
    wait_drain();
    chk("b2b_starts", n_starts - s0, 2);
    // zero bypass
    s0 = n_starts;
    send(8'd0, 8'h77);
    send(8'd5, 8'd0);
    wait_drain();
    chk("bypass_starts", n_starts - s0, 0);
    // back-pressure
    out_ready = 1'b0;
    send(8'd21, 8'd3);
    send(8'd200, 8'd9);
    send(8'd7, 8'd250);
    chk("bp_valid", {31'd0, out_valid}, 1);
    in_valid = 1'b1;
    in_a = 8'd99;
    in_b = 8'd101;
    repeat (3) begin
      chk("bp_ready", {31'd0, in_ready}, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'd99, 8'd101);
    wait_drain();
    // timeout then recovery
    hang_mode = 1;
    send(8'd45, 8'd6);
    wait_ov();
    chk("to_err", {31'd0, out_err}, 1);
    chk("to_prod", {16'd0, out_product}, 0);
    wait_drain();
    hang_mode = 0;
    send(8'd3, 8'd3);
    wait_drain();
    // reset while waiting
    fixed_d = 12;
    send(8'd50, 8'd60);
    begin
      int n = 0;
      while (!mult_start && n < 50) begin @(negedge clk); n++; end
      chk("rst_start_seen", {31'd0, mult_start}, 1);
    end
    repeat (2) @(negedge clk);
    #2 reset_a = 1'b0;
    #1;
    chk("arst_out", {14'd0, out_valid, out_err, out_product}, 0);
    chk("arst_mult", {15'd0, mult_start, mult_dataa, mult_datab}, 0);
    chk("arst_flags", {30'd0, in_ready, busy}, 2);
    repeat (2) @(posedge clk);
    #1 reset_a = 1'b1;
    fixed_d = 0;
    send(8'd7, 8'd9);
    wait_ov();
    chk("post_rst_prod", {16'd0, out_product}, 63);
    wait_drain();
    // randomized traffic
    rand_hang = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ra = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom);
          rb = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom);
          send(ra, rb);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          out_ready = $urandom_range(0, 2) != 0;
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    repeat (2) begin @(posedge clk); #1; end
    chk("end_in_q", in_q.size(), 0);
    chk("end_st_q", st_q.size(), 0);
    chk("end_busy", {31'd0, busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
